// File: rtl/level_pkg.sv
// Shared definitions for the tank level / pump controller: state encoding,
// level geometry and small helpers for reasoning about the switch vector.
package level_pkg;

    typedef enum logic [1:0] {
        IDLE,
        FILL,
        FULL,
        FAULT
    } state_t;

    localparam int NUM_LEVELS = 6;
    localparam int LEVEL_W    = 3;

    // Number of covered level switches in a vector.
    function automatic logic [LEVEL_W-1:0] countLevels(input logic [NUM_LEVELS-1:0] vec);
        logic [LEVEL_W-1:0] total;
        total = '0;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            total = total + {{(LEVEL_W-1){1'b0}}, vec[i]};
        end
        return total;
    endfunction

    // True when the vector is a gap-free thermometer code of 'cnt' ones.
    function automatic logic isThermometer(input logic [NUM_LEVELS-1:0] vec,
                                           input logic [LEVEL_W-1:0]    cnt);
        logic [NUM_LEVELS-1:0] mask;
        for (int i = 0; i < NUM_LEVELS; i++) begin
            mask[i] = (i < int'(cnt));
        end
        return (vec == mask);
    endfunction

endpackage

// File: rtl/switch_debounce.sv
// Single-bit input conditioner: two-flop synchronizer followed by a
// stability counter. The output only follows the input after it has
// disagreed with the current output for DEBOUNCE_CYCLES consecutive cycles.
module switch_debounce
    import level_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_raw,
    output logic o_stable
);

    localparam int              CNT_W   = $clog2(DEBOUNCE_CYCLES);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_meta;
    logic             r_sync;
    logic             r_stable;
    logic [CNT_W-1:0] r_count;

    // Bring the asynchronous board input into the clock domain.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
        end else begin
            r_meta <= i_raw;
            r_sync <= r_meta;
        end
    end

    // Count consecutive disagreement; accept the new value once it has held long enough.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_stable <= 1'b0;
            r_count  <= '0;
        end else if (r_sync == r_stable) begin
            r_count <= '0;
        end else if (r_count == CNT_MAX) begin
            r_stable <= r_sync;
            r_count  <= '0;
        end else begin
            r_count <= r_count + 1'b1;
        end
    end

    assign o_stable = r_stable;

endmodule

// File: rtl/level_pump_controller.sv
// Tank level pump controller: debounces the six level switches and the
// operator acknowledge, checks that the switches form a plausible
// thermometer pattern, and runs the fill/hold/fault sequencing that drives
// the pump and the Red/Green indicators.
module level_pump_controller
    import level_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int LOW_LEVEL       = 2,
    parameter int HIGH_LEVEL      = 6,
    parameter int FILL_TIMEOUT    = 50000000,
    parameter int BLINK_CYCLES    = 25000000
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [NUM_LEVELS-1:0] Sw,
    input  logic                  Ack,
    output logic                  Pump,
    output logic                  Red,
    output logic                  Green,
    output logic [LEVEL_W-1:0]    Level,
    output logic                  Fault,
    output logic [NUM_LEVELS-1:0] Stable
);

    localparam int                 TMO_W     = $clog2(FILL_TIMEOUT);
    localparam logic [TMO_W-1:0]   TMO_MAX   = TMO_W'(FILL_TIMEOUT - 1);
    localparam int                 BLINK_W   = $clog2(BLINK_CYCLES);
    localparam logic [BLINK_W-1:0] BLINK_MAX = BLINK_W'(BLINK_CYCLES - 1);
    localparam logic [LEVEL_W-1:0] LOW_L     = LEVEL_W'(LOW_LEVEL);
    localparam logic [LEVEL_W-1:0] HIGH_L    = LEVEL_W'(HIGH_LEVEL);

    logic [NUM_LEVELS-1:0] w_stable;
    logic                  w_ackSync;
    logic [LEVEL_W-1:0]    w_count;
    logic                  w_levelUp;
    state_t                w_nextState;

    logic [LEVEL_W-1:0]    r_level;
    logic [LEVEL_W-1:0]    r_levelPrev;
    logic                  r_valid;
    state_t                r_state;
    logic [TMO_W-1:0]      r_fillCount;
    logic [BLINK_W-1:0]    r_blinkCount;
    logic                  r_pump;
    logic                  r_red;
    logic                  r_green;
    logic                  r_fault;

    for (genvar g = 0; g < NUM_LEVELS; g++) begin : g_switch
        switch_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
        ) u_switchDebounce (
            .i_clk   (Clk),
            .i_rst_n (Reset_n),
            .i_raw   (Sw[g]),
            .o_stable(w_stable[g])
        );
    end

    switch_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_ackDebounce (
        .i_clk   (Clk),
        .i_rst_n (Reset_n),
        .i_raw   (Ack),
        .o_stable(w_ackSync)
    );

    assign w_count   = countLevels(w_stable);
    assign w_levelUp = (r_level > r_levelPrev);

    // Register the level count and pattern check together so they always describe the same snapshot.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_level     <= '0;
            r_levelPrev <= '0;
            r_valid     <= 1'b1;
        end else begin
            r_level     <= w_count;
            r_levelPrev <= r_level;
            r_valid     <= isThermometer(w_stable, w_count);
        end
    end

    // Dry-run timer: counts cycles in FILL since entry or since the level last rose.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_fillCount <= '0;
        end else if (r_state != FILL || w_levelUp) begin
            r_fillCount <= '0;
        end else begin
            r_fillCount <= r_fillCount + 1'b1;
        end
    end

    // Next-state rules; a bad pattern beats the timeout, which beats the level thresholds.
    always_comb begin
        w_nextState = r_state;
        case (r_state)
            IDLE: begin
                if (!r_valid)                w_nextState = FAULT;
                else if (r_level <= LOW_L)   w_nextState = FILL;
                else if (r_level >= HIGH_L)  w_nextState = FULL;
            end
            FILL: begin
                if (!r_valid)                    w_nextState = FAULT;
                else if (r_fillCount == TMO_MAX) w_nextState = FAULT;
                else if (r_level >= HIGH_L)      w_nextState = FULL;
            end
            FULL: begin
                if (!r_valid)                w_nextState = FAULT;
                else if (r_level < HIGH_L)   w_nextState = IDLE;
            end
            FAULT: begin
                if (w_ackSync && r_valid)    w_nextState = IDLE;
            end
            default: w_nextState = IDLE;
        endcase
    end

    // State register with outputs decoded from the next state, including the fault blink.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_state      <= IDLE;
            r_pump       <= 1'b0;
            r_red        <= 1'b0;
            r_green      <= 1'b1;
            r_fault      <= 1'b0;
            r_blinkCount <= '0;
        end else begin
            r_state <= w_nextState;
            r_pump  <= (w_nextState == FILL);
            r_green <= (w_nextState == IDLE) || (w_nextState == FILL);
            r_fault <= (w_nextState == FAULT);
            if (w_nextState == FAULT && r_state == FAULT) begin
                if (r_blinkCount == BLINK_MAX) begin
                    r_blinkCount <= '0;
                    r_red        <= ~r_red;
                end else begin
                    r_blinkCount <= r_blinkCount + 1'b1;
                end
            end else begin
                r_blinkCount <= '0;
                r_red        <= (w_nextState == FULL) || (w_nextState == FAULT);
            end
        end
    end

    assign Pump   = r_pump;
    assign Red    = r_red;
    assign Green  = r_green;
    assign Fault  = r_fault;
    assign Level  = r_level;
    assign Stable = w_stable;

endmodule

// File: tb/tb_level_pump_controller.sv
// Self-checking bench for level_pump_controller. A behavioural model tracks
// the expected outputs each cycle; directed scenarios add literal checks.
module tb_level_pump_controller;

    localparam int DEB  = 4;
    localparam int LOW  = 2;
    localparam int HIGH = 6;
    localparam int FT   = 64;
    localparam int BC   = 8;

    typedef enum {mIdle, mFill, mFull, mFault} modelState_t;

    logic       Clk = 1'b0;
    logic       Reset_n = 1'b0;
    logic [5:0] Sw = 6'b000111;
    logic       Ack = 1'b0;
    logic       Pump;
    logic       Red;
    logic       Green;
    logic [2:0] Level;
    logic       Fault;
    logic [5:0] Stable;

    int total = 0;
    int bad   = 0;

    // Model state
    logic [5:0]  mD1, mD2;
    logic [5:0]  mWin [DEB];
    logic        mA1, mA2;
    logic        mAWin [DEB];
    logic [5:0]  mStable;
    logic        mAckStable;
    int          mLevel, mLevelPrev;
    bit          mValid;
    modelState_t mState;
    int          fillAge, faultAge;

    level_pump_controller #(
        .DEBOUNCE_CYCLES(DEB),
        .LOW_LEVEL      (LOW),
        .HIGH_LEVEL     (HIGH),
        .FILL_TIMEOUT   (FT),
        .BLINK_CYCLES   (BC)
    ) dut (
        .Clk    (Clk),
        .Reset_n(Reset_n),
        .Sw     (Sw),
        .Ack    (Ack),
        .Pump   (Pump),
        .Red    (Red),
        .Green  (Green),
        .Level  (Level),
        .Fault  (Fault),
        .Stable (Stable)
    );

    always #5 Clk = ~Clk;

    function automatic logic [5:0] thermoOf(input int n);
        return 6'((1 << n) - 1);
    endfunction

    task automatic checkOne(input string name, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic resetModel();
        mD1 = '0; mD2 = '0; mA1 = 1'b0; mA2 = 1'b0;
        for (int k = 0; k < DEB; k++) begin
            mWin[k]  = '0;
            mAWin[k] = 1'b0;
        end
        mStable    = '0;
        mAckStable = 1'b0;
        mLevel     = 0;
        mLevelPrev = 0;
        mValid     = 1'b1;
        mState     = mIdle;
        fillAge    = 0;
        faultAge   = 0;
    endtask

    // One clock of the specification's behaviour, using pre-edge values for every decision.
    task automatic stepModel();
        logic [5:0]  oldStable;
        int          oldLevel, oldPrev;
        bit          oldValid, oldAck, flip, levelUp;
        modelState_t nxt;
        oldStable = mStable;
        oldLevel  = mLevel;
        oldPrev   = mLevelPrev;
        oldValid  = mValid;
        oldAck    = mAckStable;

        for (int k = DEB - 1; k > 0; k--) begin
            mWin[k]  = mWin[k-1];
            mAWin[k] = mAWin[k-1];
        end
        mWin[0]  = mD2; mD2 = mD1; mD1 = Sw;
        mAWin[0] = mA2; mA2 = mA1; mA1 = Ack;

        // A bit flips once the last DEB synchronized samples all disagree with it.
        for (int b = 0; b < 6; b++) begin
            flip = 1'b1;
            for (int k = 0; k < DEB; k++) if (mWin[k][b] == oldStable[b]) flip = 1'b0;
            if (flip) mStable[b] = ~oldStable[b];
        end
        flip = 1'b1;
        for (int k = 0; k < DEB; k++) if (mAWin[k] == oldAck) flip = 1'b0;
        if (flip) mAckStable = ~oldAck;

        mLevel     = $countones(oldStable);
        mValid     = (oldStable == thermoOf(mLevel));
        mLevelPrev = oldLevel;
        levelUp    = (oldLevel > oldPrev);

        nxt = mState;
        case (mState)
            mIdle:  if (!oldValid) nxt = mFault;
                    else if (oldLevel <= LOW) nxt = mFill;
                    else if (oldLevel >= HIGH) nxt = mFull;
            mFill:  if (!oldValid || fillAge == FT - 1) nxt = mFault;
                    else if (oldLevel >= HIGH) nxt = mFull;
            mFull:  if (!oldValid) nxt = mFault;
                    else if (oldLevel < HIGH) nxt = mIdle;
            mFault: if (oldAck && oldValid) nxt = mIdle;
        endcase

        if (mState == mFill && nxt == mFill) fillAge = levelUp ? 0 : fillAge + 1;
        else fillAge = 0;
        if (mState == mFault && nxt == mFault) faultAge++;
        else faultAge = 0;
        mState = nxt;
    endtask

    task automatic checkOutput();
        checkOne("pump",   int'(Pump),   int'(mState == mFill));
        checkOne("green",  int'(Green),  int'(mState == mIdle || mState == mFill));
        checkOne("fault",  int'(Fault),  int'(mState == mFault));
        checkOne("red",    int'(Red),    int'(mState == mFull ||
                                             (mState == mFault && ((faultAge / BC) % 2 == 0))));
        checkOne("level",  int'(Level),  mLevel);
        checkOne("stable", int'(Stable), int'(mStable));
    endtask

    task automatic applyStimulus(input logic [5:0] sw, input logic ack, input int cycles);
        Sw  = sw;
        Ack = ack;
        repeat (cycles) @(posedge Clk);
        #1;
    endtask

    task automatic pulseReset();
        #2 Reset_n = 1'b0;
        @(posedge Clk);
        @(posedge Clk);
        #1 Reset_n = 1'b1;
    endtask

    // Model process
    initial begin
        resetModel();
        forever begin
            @(posedge Clk or negedge Reset_n);
            if (!Reset_n) resetModel();
            else stepModel();
        end
    end

    // Compare process
    initial begin
        forever begin
            @(negedge Clk);
            checkOutput();
        end
    end

    initial begin
        logic [5:0] sw;
        logic       ack;

        // Scenario 1: reset, run, asynchronous reset pulse mid-fill, debounce latency after release
        repeat (3) @(posedge Clk);
        #1 Reset_n = 1'b1;
        applyStimulus(6'b000111, 1'b0, 20);
        checkOne("fill_before_reset_pump", int'(Pump), 1);
        #2 Reset_n = 1'b0;
        #1;
        checkOne("async_reset_pump",   int'(Pump),   0);
        checkOne("async_reset_green",  int'(Green),  1);
        checkOne("async_reset_red",    int'(Red),    0);
        checkOne("async_reset_fault",  int'(Fault),  0);
        checkOne("async_reset_level",  int'(Level),  0);
        checkOne("async_reset_stable", int'(Stable), 0);
        @(posedge Clk);
        #1 Reset_n = 1'b1;
        repeat (5) @(posedge Clk);
        #1 checkOne("stable_at_5", int'(Stable), 0);
        @(posedge Clk);
        #1 checkOne("stable_at_6", int'(Stable), 7);
        checkOne("level_at_6", int'(Level), 0);
        @(posedge Clk);
        #1 checkOne("level_at_7", int'(Level), 3);

        // Scenario 2: fill from empty, step up to full, drop back into hysteresis band
        applyStimulus(6'b000000, 1'b0, 30);
        checkOne("empty_pump",  int'(Pump),  1);
        checkOne("empty_green", int'(Green), 1);
        for (int lv = 1; lv <= 6; lv++) begin
            applyStimulus(thermoOf(lv), 1'b0, 20);
            checkOne("step_level", int'(Level), lv);
        end
        checkOne("full_pump",  int'(Pump),  0);
        checkOne("full_red",   int'(Red),   1);
        checkOne("full_green", int'(Green), 0);
        applyStimulus(6'b000111, 1'b0, 20);
        checkOne("band_pump",  int'(Pump),  0);
        checkOne("band_green", int'(Green), 1);

        // Scenario 3: short glitch on the top switch never reaches Stable
        applyStimulus(6'b000011, 1'b0, 15);
        checkOne("low_pump", int'(Pump), 1);
        applyStimulus(6'b100011, 1'b0, 3);
        applyStimulus(6'b000011, 1'b0, 10);
        checkOne("glitch_stable", int'(Stable), 3);
        checkOne("glitch_pump",   int'(Pump),   1);

        // Scenario 4: gap pattern faults; Ack ignored until the pattern is fixed
        applyStimulus(6'b001011, 1'b0, 20);
        checkOne("gap_fault", int'(Fault), 1);
        checkOne("gap_pump",  int'(Pump),  0);
        applyStimulus(6'b001011, 1'b1, 20);
        checkOne("gap_ack_fault", int'(Fault), 1);
        applyStimulus(6'b001011, 1'b0, 20);
        applyStimulus(6'b001111, 1'b0, 20);
        checkOne("fixed_noack_fault", int'(Fault), 1);
        applyStimulus(6'b001111, 1'b1, 20);
        checkOne("fixed_ack_fault", int'(Fault), 0);
        checkOne("fixed_ack_green", int'(Green), 1);
        checkOne("fixed_ack_level", int'(Level), 4);

        // Scenario 5: level stuck low in FILL times out
        applyStimulus(6'b000001, 1'b0, 30);
        checkOne("stuck_pump", int'(Pump), 1);
        applyStimulus(6'b000001, 1'b0, 70);
        checkOne("timeout_fault", int'(Fault), 1);
        checkOne("timeout_pump",  int'(Pump),  0);

        // Scenario 6: invalid high-count pattern while filling goes to FAULT, not FULL
        applyStimulus(6'b000001, 1'b1, 20);
        applyStimulus(6'b000001, 1'b0, 15);
        checkOne("refill_pump", int'(Pump), 1);
        applyStimulus(6'b000111, 1'b0, 20);
        checkOne("refill_level", int'(Level), 3);
        applyStimulus(6'b111110, 1'b0, 12);
        checkOne("bad_high_fault", int'(Fault), 1);
        checkOne("bad_high_red",   int'(Red),   1);
        checkOne("bad_high_pump",  int'(Pump),  0);

        // Randomized phase checked by the model every cycle
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 99) < 75) sw = thermoOf($urandom_range(0, 6));
            else sw = 6'($urandom);
            ack = ($urandom_range(0, 9) < 2);
            applyStimulus(sw, ack, $urandom_range(1, 40));
            if ($urandom_range(0, 99) < 3) pulseReset();
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
